// File: rtl/booth_pkg.sv
// Shared types, default widths and helpers for the Booth product accumulator.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int PW_DEF     = 8;
    localparam int AW_DEF     = 16;
    localparam int MAXLEN_DEF = 16;

    // Helpers work on a fixed wide vector; callers cast down to their width.
    localparam int XW = 64;

    function automatic logic [XW-1:0] sext(input logic [XW-1:0] v, input int w);
        logic [XW-1:0] r;
        r = v;
        for (int i = 0; i < XW; i++) begin
            if (i >= w) r[i] = v[w-1];
        end
        return r;
    endfunction

    function automatic logic [XW-1:0] sat_pos(input int aw);
        return (XW'(1) << (aw - 1)) - XW'(1);
    endfunction

    function automatic logic [XW-1:0] sat_neg(input int aw);
        return ~sat_pos(aw);
    endfunction

endpackage

// File: rtl/booth_acc_add.sv
// Combinational accumulate step: acc + sext(prod) with signed overflow detect.
// Clamps to the signed AW-bit range on overflow when ACC_SAT_EN is defined.
module booth_acc_add
    import booth_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [PW-1:0] prod,
    input  logic [AW-1:0] acc,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    logic [AW-1:0] prod_ext;
    logic [AW:0]   full;

    always_comb begin
        prod_ext = AW'(sext(XW'(prod), PW));
        full     = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};
        // Top two bits of the AW+1-bit sum disagree exactly on signed overflow.
        ovf      = full[AW] ^ full[AW-1];
`ifdef ACC_SAT_EN
        if (ovf) begin
            sum = full[AW] ? AW'(sat_neg(AW)) : AW'(sat_pos(AW));
        end else begin
            sum = full[AW-1:0];
        end
`else
        sum = full[AW-1:0];
`endif
    end

endmodule

// File: rtl/booth_acc.sv
// Signed product accumulator with valid/ready in and out; optional saturation
// via the ACC_SAT_EN macro (default build wraps modulo 2^AW).
module booth_acc
    import booth_pkg::*;
#(
    parameter int PW     = PW_DEF,
    parameter int AW     = AW_DEF,
    parameter int MAXLEN = MAXLEN_DEF,
    localparam int CW    = $clog2(MAXLEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_ovf,
    output state_t        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready and out_valid are decoded from state alone, never from valid.

    localparam logic [CW-1:0] MAX_CNT = CW'(MAXLEN);

    state_t        state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic [AW-1:0] add_acc;
    logic [AW-1:0] add_sum;
    logic          add_ovf;
    logic [CW-1:0] cnt_next;
    logic          terminal;
    logic          accept;

    // Starting a sum adds to zero, so the first term needs no separate path.
    always_comb begin
        add_acc  = (state == IDLE) ? '0 : acc;
        cnt_next = (state == IDLE) ? CW'(1) : cnt + CW'(1);
        terminal = in_last || (cnt_next == MAX_CNT);
        accept   = in_valid && in_ready;
    end

    booth_acc_add #(
        .PW(PW),
        .AW(AW)
    ) u_add (
        .prod(in_prod),
        .acc (add_acc),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        acc   <= add_sum;
                        cnt   <= cnt_next;
                        ovf   <= ((state == ACC) && ovf) || add_ovf;
                        state <= terminal ? HOLD : ACC;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;
    assign dbg_state = state;

endmodule

// File: tb/tb_booth_acc.sv
// Directed bench for booth_acc: default widths, AW=8 (wrap or ACC_SAT_EN) and MAXLEN=4.
module tb_booth_acc;
    import booth_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] prod;
    logic last;

    // default instance
    logic v_d, or_d, rdy_d, ov_d, ovf_d;
    logic [15:0] sum_d;
    logic [4:0] cnt_d;
    state_t dbg_d;
    // AW=8 instance
    logic v_a, or_a, rdy_a, ov_a, ovf_a;
    logic [7:0] sum_a;
    logic [4:0] cnt_a;
    state_t dbg_a;
    // MAXLEN=4 instance
    logic v_m, or_m, rdy_m, ov_m, ovf_m;
    logic [15:0] sum_m;
    logic [2:0] cnt_m;
    state_t dbg_m;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_acc u_def (
        .clk(clk), .rst(rst), .in_valid(v_d), .in_ready(rdy_d), .in_prod(prod),
        .in_last(last), .out_valid(ov_d), .out_ready(or_d), .out_sum(sum_d),
        .out_count(cnt_d), .out_ovf(ovf_d), .dbg_state(dbg_d)
    );

    booth_acc #(.AW(8)) u_a8 (
        .clk(clk), .rst(rst), .in_valid(v_a), .in_ready(rdy_a), .in_prod(prod),
        .in_last(last), .out_valid(ov_a), .out_ready(or_a), .out_sum(sum_a),
        .out_count(cnt_a), .out_ovf(ovf_a), .dbg_state(dbg_a)
    );

    booth_acc #(.MAXLEN(4)) u_m4 (
        .clk(clk), .rst(rst), .in_valid(v_m), .in_ready(rdy_m), .in_prod(prod),
        .in_last(last), .out_valid(ov_m), .out_ready(or_m), .out_sum(sum_m),
        .out_count(cnt_m), .out_ovf(ovf_m), .dbg_state(dbg_m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        prod = '0; last = 1'b0;
        v_d = 0; or_d = 0; v_a = 0; or_a = 1; v_m = 0; or_m = 0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(ov_d), 32'd0);
        check("rst_ready", 32'(rdy_d), 32'd1);
        check("rst_sum", 32'(sum_d), 32'd0);
        check("rst_count", 32'(cnt_d), 32'd0);
        check("rst_ovf", 32'(ovf_d), 32'd0);
        check("rst_state", 32'(dbg_d), 32'(IDLE));
        rst = 1'b0;

        // 4 + 6 + 12 = 22
        v_d = 1; or_d = 1; prod = 8'd4; last = 0;
        tick();
        check("s1_acc_state", 32'(dbg_d), 32'(ACC));
        check("s1_acc_ready", 32'(rdy_d), 32'd1);
        check("s1_acc_valid", 32'(ov_d), 32'd0);
        prod = 8'd6;
        tick();
        prod = 8'd12; last = 1;
        tick();
        check("s1_valid", 32'(ov_d), 32'd1);
        check("s1_sum", 32'(sum_d), 32'd22);
        check("s1_count", 32'(cnt_d), 32'd3);
        check("s1_ovf", 32'(ovf_d), 32'd0);
        check("s1_ready", 32'(rdy_d), 32'd0);
        v_d = 0; last = 0;
        tick();
        check("s1_valid_drop", 32'(ov_d), 32'd0);
        check("s1_ready_back", 32'(rdy_d), 32'd1);

        // single negative term sign-extends
        v_d = 1; prod = 8'hFB; last = 1;
        tick();
        check("neg_sum", 32'(sum_d), 32'h0000FFFB);
        check("neg_count", 32'(cnt_d), 32'd1);
        check("neg_valid", 32'(ov_d), 32'd1);
        v_d = 0; last = 0;
        tick();

        // AW=8: 100 + 100
        v_a = 1; prod = 8'd100; last = 0;
        tick();
        last = 1;
        tick();
`ifdef ACC_SAT_EN
        check("a8_pos_sum", 32'(sum_a), 32'h7F);
`else
        check("a8_pos_sum", 32'(sum_a), 32'hC8);
`endif
        check("a8_pos_ovf", 32'(ovf_a), 32'd1);
        check("a8_pos_valid", 32'(ov_a), 32'd1);
        v_a = 0; last = 0;
        tick();

        // AW=8: -64 * 3; first two fit, third overflows
        v_a = 1; prod = 8'hC0;
        tick();
        check("a8_neg1_ovf_clear", 32'(ovf_a), 32'd0);
        check("a8_neg1_sum", 32'(sum_a), 32'hC0);
        tick();
        check("a8_neg2_sum", 32'(sum_a), 32'h80);
        check("a8_neg2_ovf", 32'(ovf_a), 32'd0);
        last = 1;
        tick();
`ifdef ACC_SAT_EN
        check("a8_neg_sum", 32'(sum_a), 32'h80);
`else
        check("a8_neg_sum", 32'(sum_a), 32'h40);
`endif
        check("a8_neg_ovf", 32'(ovf_a), 32'd1);
        check("a8_neg_count", 32'(cnt_a), 32'd3);
        v_a = 0; last = 0;
        tick();

        // MAXLEN=4: forced close after four terms
        v_m = 1; prod = 8'd1; last = 0;
        repeat (3) tick();
        check("m4_cnt3", 32'(cnt_m), 32'd3);
        check("m4_open", 32'(ov_m), 32'd0);
        tick();
        check("m4_valid", 32'(ov_m), 32'd1);
        check("m4_count", 32'(cnt_m), 32'd4);
        check("m4_sum", 32'(sum_m), 32'd4);
        check("m4_ready", 32'(rdy_m), 32'd0);
        tick();
        check("m4_hold_valid", 32'(ov_m), 32'd1);
        check("m4_hold_count", 32'(cnt_m), 32'd4);
        or_m = 1;
        tick();
        check("m4_idle_valid", 32'(ov_m), 32'd0);
        check("m4_idle_ready", 32'(rdy_m), 32'd1);
        check("m4_idle_state", 32'(dbg_m), 32'(IDLE));
        or_m = 0;
        tick();
        check("m4_new_count", 32'(cnt_m), 32'd1);
        check("m4_new_sum", 32'(sum_m), 32'd1);
        check("m4_new_state", 32'(dbg_m), 32'(ACC));
        last = 1;
        tick();
        check("m4_new2_count", 32'(cnt_m), 32'd2);
        check("m4_new2_sum", 32'(sum_m), 32'd2);
        v_m = 0; last = 0; or_m = 1;
        tick();

        // backpressure on result
        or_d = 0; v_d = 1; prod = 8'd9; last = 1;
        tick();
        prod = 8'd50; last = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", 32'(ov_d), 32'd1);
            check("bp_sum", 32'(sum_d), 32'd9);
            check("bp_count", 32'(cnt_d), 32'd1);
            check("bp_ready", 32'(rdy_d), 32'd0);
        end
        or_d = 1; v_d = 0;
        tick();
        check("bp_release_valid", 32'(ov_d), 32'd0);
        check("bp_release_ready", 32'(rdy_d), 32'd1);

        // asynchronous reset mid-sum
        v_d = 1; prod = 8'd5; last = 0;
        tick();
        prod = 8'd7;
        tick();
        check("mid_state", 32'(dbg_d), 32'(ACC));
        check("mid_sum", 32'(sum_d), 32'd12);
        v_d = 0;
        #2 rst = 1'b1;
        #1;
        check("arst_sum", 32'(sum_d), 32'd0);
        check("arst_count", 32'(cnt_d), 32'd0);
        check("arst_ovf", 32'(ovf_d), 32'd0);
        check("arst_valid", 32'(ov_d), 32'd0);
        check("arst_ready", 32'(rdy_d), 32'd1);
        check("arst_state", 32'(dbg_d), 32'(IDLE));
        #1 rst = 1'b0;
        v_d = 1; prod = 8'd3; last = 1;
        tick();
        check("post_rst_sum", 32'(sum_d), 32'd3);
        check("post_rst_count", 32'(cnt_d), 32'd1);
        check("post_rst_valid", 32'(ov_d), 32'd1);
        v_d = 0; last = 0;
        tick();
        check("post_rst_done", 32'(ov_d), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
